// File: rtl/u_rx.sv
// UART receiver: 2-flop synchronizer plus oversampled start/data/stop FSM.
// Frames are LSB first with one stop bit; good bytes pulse rx_done, bad stop bits pulse rx_frame_err.
module u_rx #(
  parameter int unsigned width        = 8,
  parameter int unsigned no_of_sample = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_data_in,
  input  logic             baud_en_rx,
  output logic [width-1:0] rx_data_out,
  output logic             rx_done,
  output logic             rx_active,
  output logic             rx_frame_err
);

  localparam int unsigned CntW = $clog2(no_of_sample);
  localparam int unsigned BitW = $clog2(width);

  localparam logic [CntW-1:0] HalfM1  = CntW'(no_of_sample / 2 - 1);
  localparam logic [CntW-1:0] FullM1  = CntW'(no_of_sample - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(width - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StCleanup} state_e;

  state_e            state_q;
  logic              meta_q, rxs_q;
  logic [CntW-1:0]   cnt_q;
  logic [BitW-1:0]   bit_q;
  logic [width-1:0]  shift_q;
  logic [width-1:0]  data_q;
  logic              done_q, err_q, active_q;

  // Both flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      rxs_q  <= 1'b1;
    end else begin
      meta_q <= rx_data_in;
      rxs_q  <= meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          bit_q <= '0;
          if (!rxs_q) begin
            state_q  <= StStart;
            active_q <= 1'b1;
          end
        end
        StStart: begin
          if (baud_en_rx) begin
            if (cnt_q == HalfM1) begin
              cnt_q <= '0;
              if (!rxs_q) begin
                state_q <= StData;
              end else begin
                // Line went back high before mid start bit: treat as noise.
                state_q  <= StIdle;
                active_q <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StData: begin
          if (baud_en_rx) begin
            if (cnt_q == FullM1) begin
              cnt_q   <= '0;
              shift_q <= {rxs_q, shift_q[width-1:1]};
              if (bit_q == LastBit) begin
                state_q <= StStop;
              end else begin
                bit_q <= bit_q + BitW'(1);
              end
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StStop: begin
          if (baud_en_rx) begin
            if (cnt_q == FullM1) begin
              cnt_q <= '0;
              if (rxs_q) begin
                data_q <= shift_q;
                done_q <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
              state_q <= StCleanup;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StCleanup: begin
          // Wait out a held-low line (break) before re-arming start detection.
          if (rxs_q) begin
            state_q  <= StIdle;
            active_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= StIdle;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data_out  = data_q;
  assign rx_done      = done_q;
  assign rx_active    = active_q;
  assign rx_frame_err = err_q;

endmodule
